// File: rtl/odu_frame_checker_if.sv
// ODU frame checker bus: generator word stream, config port and status outputs.
interface odu_frame_checker_if #(
    parameter int unsigned DATA_W = 384,
    parameter int unsigned CHID_W = 7
);
    logic [DATA_W+2:0] data_in;
    logic [CHID_W-1:0] chid_in;
    logic              cfg_n_cs;
    logic              cfg_n_we;
    logic              cfg_n_oe;
    logic [3:0]        cfg_addr;
    logic [15:0]       cfg_din;
    logic [15:0]       cfg_dout;
    logic              lock;
    logic              err_pulse;

    modport master (
        output data_in, chid_in, cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        input  cfg_dout, lock, err_pulse
    );

    modport slave (
        input  data_in, chid_in, cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        output cfg_dout, lock, err_pulse
    );
endinterface

// File: rtl/odu_frame_checker.sv
// ODU frame alignment checker: tracks row/frame start flags of one channel
// (or all channels), hunts/presyncs/locks, and counts frames and errors.
module odu_frame_checker #(
    parameter int unsigned DATA_W = 384,
    parameter int unsigned CHID_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    odu_frame_checker_if.slave bus
);
    localparam int unsigned WPOS_W = 12;
    localparam int unsigned RPOS_W = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SEL_W  = 7;
    localparam int unsigned CMP_W  = (CHID_W > SEL_W) ? CHID_W : SEL_W;

    localparam logic [WPOS_W-1:0] WPR_RST = 12'd80;
    localparam logic [RPOS_W-1:0] RPF_RST = 4'd4;

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_WPR   = 4'h1;
    localparam logic [3:0] ADDR_RPF   = 4'h2;
    localparam logic [3:0] ADDR_STAT  = 4'h3;
    localparam logic [3:0] ADDR_FCNT  = 4'h4;
    localparam logic [3:0] ADDR_ECNT  = 4'h5;
    localparam logic [3:0] ADDR_WPOS  = 4'h6;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WPOS_W-1:0]   wpos_q, wpos_d;
    logic [RPOS_W-1:0]   rpos_q, rpos_d;
    logic                lock_q, err_pulse_q;
    logic [15:0]         cfg_dout_q;

    logic                ctrl_en_q, ctrl_mon_q;
    logic [SEL_W-1:0]    ctrl_sel_q;
    logic [WPOS_W-1:0]   wpr_q;
    logic [RPOS_W-1:0]   rpf_q;
    logic [CNT_W-1:0]    frame_cnt_q, err_cnt_q;
    logic                sticky_q;

    logic                cfg_wr, cfg_rd;
    logic                wr_ctrl, wr_wpr, wr_rpf;
    logic                clear_c, force_hunt, accept;
    logic                word_fs, word_rs, exp_rs, exp_fs;
    logic [WPOS_W-1:0]   wpr_eff, wpos_adv, wpos_acq;
    logic [RPOS_W-1:0]   rpf_eff, rpos_adv, rpos_acq;
    logic [WPOS_W:0]     wpos_inc;
    logic [RPOS_W:0]     rpos_inc;
    logic                err_c, frame_inc_c;
    logic [15:0]         rd_data;

    // Payload and the spare CTRL bit never influence checking.
    logic unused_bits;
    assign unused_bits = ^{bus.data_in[DATA_W-1:0], bus.cfg_din[15]};

    assign cfg_wr  = !bus.cfg_n_cs && !bus.cfg_n_we;
    assign cfg_rd  = !bus.cfg_n_cs && !bus.cfg_n_oe;
    assign wr_ctrl = cfg_wr && (bus.cfg_addr == ADDR_CTRL);
    assign wr_wpr  = cfg_wr && (bus.cfg_addr == ADDR_WPR);
    assign wr_rpf  = cfg_wr && (bus.cfg_addr == ADDR_RPF);
    assign clear_c = wr_ctrl && bus.cfg_din[1];

    // Geometry changes and disabling restart alignment from a clean HUNT.
    assign force_hunt = wr_wpr || wr_rpf || !ctrl_en_q || (wr_ctrl && !bus.cfg_din[0]);

    assign word_fs = bus.data_in[DATA_W+1];
    assign word_rs = bus.data_in[DATA_W];
    assign accept  = bus.data_in[DATA_W+2] && ctrl_en_q &&
                     (ctrl_mon_q || (CMP_W'(bus.chid_in) == CMP_W'(ctrl_sel_q)));

    assign wpr_eff = (wpr_q == '0) ? WPOS_W'(1) : wpr_q;
    assign rpf_eff = (rpf_q == '0) ? RPOS_W'(1) : rpf_q;
    assign exp_rs  = (wpos_q == '0);
    assign exp_fs  = exp_rs && (rpos_q == '0);

    // Position of the word following the current one, with row/frame wrap.
    always_comb begin
        wpos_inc = {1'b0, wpos_q} + (WPOS_W+1)'(1);
        rpos_inc = {1'b0, rpos_q} + (RPOS_W+1)'(1);
        wpos_adv = wpos_inc[WPOS_W-1:0];
        rpos_adv = rpos_q;
        if (wpos_inc >= {1'b0, wpr_eff}) begin
            wpos_adv = '0;
            rpos_adv = (rpos_inc >= {1'b0, rpf_eff}) ? '0 : rpos_inc[RPOS_W-1:0];
        end
    end

    // Position after a frame start seen from HUNT (the word after 0/0).
    assign wpos_acq = (wpr_eff == WPOS_W'(1)) ? '0 : WPOS_W'(1);
    assign rpos_acq = ((wpr_eff == WPOS_W'(1)) && (rpf_eff != RPOS_W'(1))) ? RPOS_W'(1) : '0;

    // Alignment FSM next-state, position and event decode.
    always_comb begin
        state_d     = state_q;
        wpos_d      = wpos_q;
        rpos_d      = rpos_q;
        err_c       = 1'b0;
        frame_inc_c = 1'b0;
        if (force_hunt) begin
            state_d = HUNT;
            wpos_d  = '0;
            rpos_d  = '0;
        end else if (accept) begin
            case (state_q)
                HUNT: begin
                    if (word_fs && word_rs) begin
                        state_d = PRESYNC;
                        wpos_d  = wpos_acq;
                        rpos_d  = rpos_acq;
                    end else if (word_fs) begin
                        err_c = 1'b1;
                    end
                end
                PRESYNC, SYNC: begin
                    if ((word_rs != exp_rs) || (word_fs != exp_fs)) begin
                        err_c = 1'b1;
                        if (word_fs && word_rs) begin
                            state_d = PRESYNC;
                            wpos_d  = wpos_acq;
                            rpos_d  = rpos_acq;
                        end else begin
                            state_d = HUNT;
                            wpos_d  = '0;
                            rpos_d  = '0;
                        end
                    end else begin
                        wpos_d = wpos_adv;
                        rpos_d = rpos_adv;
                        if (word_fs) begin
                            state_d     = SYNC;
                            frame_inc_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    wpos_d  = '0;
                    rpos_d  = '0;
                end
            endcase
        end
    end

    // State, position and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            wpos_q      <= '0;
            rpos_q      <= '0;
            lock_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wpos_q      <= wpos_d;
            rpos_q      <= rpos_d;
            lock_q      <= (state_d == SYNC);
            err_pulse_q <= err_c;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q  <= 1'b0;
            ctrl_mon_q <= 1'b0;
            ctrl_sel_q <= '0;
            wpr_q      <= WPR_RST;
            rpf_q      <= RPF_RST;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q  <= bus.cfg_din[0];
                ctrl_mon_q <= bus.cfg_din[7];
                ctrl_sel_q <= bus.cfg_din[14:8];
            end
            if (wr_wpr) wpr_q <= bus.cfg_din[WPOS_W-1:0];
            if (wr_rpf) rpf_q <= bus.cfg_din[RPOS_W-1:0];
        end
    end

    // Saturating frame/error counters and sticky error; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            sticky_q    <= 1'b0;
        end else if (clear_c) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            sticky_q    <= 1'b0;
        end else begin
            if (frame_inc_c && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (err_c && (err_cnt_q != '1))         err_cnt_q   <= err_cnt_q + CNT_W'(1);
            if (err_c)                              sticky_q    <= 1'b1;
        end
    end

    // Read mux over the register map; unmapped addresses read zero.
    always_comb begin
        rd_data = '0;
        case (bus.cfg_addr)
            ADDR_CTRL: rd_data = {1'b0, ctrl_sel_q, ctrl_mon_q, 6'b0, ctrl_en_q};
            ADDR_WPR:  rd_data = {4'b0, wpr_q};
            ADDR_RPF:  rd_data = {12'b0, rpf_q};
            ADDR_STAT: rd_data = {13'b0, sticky_q, state_q};
            ADDR_FCNT: rd_data = frame_cnt_q;
            ADDR_ECNT: rd_data = err_cnt_q;
            ADDR_WPOS: rd_data = {rpos_q, wpos_q};
            default:   rd_data = '0;
        endcase
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cfg_dout_q <= '0;
        else if (cfg_rd) cfg_dout_q <= rd_data;
    end

    assign bus.cfg_dout  = cfg_dout_q;
    assign bus.lock      = lock_q;
    assign bus.err_pulse = err_pulse_q;
endmodule

// File: tb/tb_odu_frame_checker.sv
// Self-checking bench for odu_frame_checker: register table, directed
// alignment scenarios and randomized traffic against a frame-index model.
module tb_odu_frame_checker;
    localparam int unsigned DATA_W = 384;
    localparam int unsigned CHID_W = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    odu_frame_checker_if #(.DATA_W(DATA_W), .CHID_W(CHID_W)) bus ();
    odu_frame_checker #(.DATA_W(DATA_W), .CHID_W(CHID_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: frame position as one linear index within the frame.
    int          m_state, m_idx, m_wpr, m_rpf, m_fcnt, m_ecnt, m_chid;
    bit          m_en, m_mon, m_sticky, m_lock, m_err;
    logic [15:0] m_dout;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] exp;
        string       name;
    } rd_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_wpr = 80; m_rpf = 4; m_fcnt = 0; m_ecnt = 0;
        m_chid = 0; m_en = 0; m_mon = 0; m_sticky = 0; m_lock = 0; m_err = 0;
        m_dout = 16'h0000;
    endtask

    function automatic logic [15:0] model_read(input int addr);
        int w;
        w = (m_wpr == 0) ? 1 : m_wpr;
        case (addr)
            0: return 16'((m_chid << 8) | (int'(m_mon) << 7) | int'(m_en));
            1: return 16'(m_wpr);
            2: return 16'(m_rpf);
            3: return 16'((int'(m_sticky) << 2) | m_state);
            4: return 16'(m_fcnt);
            5: return 16'(m_ecnt);
            6: return 16'(((m_idx / w) << 12) | (m_idx % w));
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit wr, rd, acc, fs, rs, force_h, clr, err, finc;
        int addr, din, w, r, flen;
        logic [15:0] rdv;
        wr   = !bus.cfg_n_cs && !bus.cfg_n_we;
        rd   = !bus.cfg_n_cs && !bus.cfg_n_oe;
        addr = int'(bus.cfg_addr);
        din  = int'(bus.cfg_din);
        fs   = bus.data_in[DATA_W+1];
        rs   = bus.data_in[DATA_W];
        rdv  = model_read(addr);
        w    = (m_wpr == 0) ? 1 : m_wpr;
        r    = (m_rpf == 0) ? 1 : m_rpf;
        flen = w * r;
        acc  = bus.data_in[DATA_W+2] && m_en && (m_mon || int'(bus.chid_in) == m_chid);
        force_h = !m_en || (wr && (addr == 1 || addr == 2 || (addr == 0 && (din & 1) == 0)));
        err = 0; finc = 0;
        if (force_h) begin
            m_state = 0; m_idx = 0;
        end else if (acc) begin
            if (m_state == 0) begin
                if (fs && rs) begin m_state = 1; m_idx = 1 % flen; end
                else if (fs) err = 1;
            end else if (rs != (m_idx % w == 0) || fs != (m_idx == 0)) begin
                err = 1;
                if (fs && rs) begin m_state = 1; m_idx = 1 % flen; end
                else begin m_state = 0; m_idx = 0; end
            end else begin
                m_idx = (m_idx + 1) % flen;
                if (fs) begin m_state = 2; finc = 1; end
            end
        end
        clr = wr && addr == 0 && (din & 2) != 0;
        if (clr) begin
            m_fcnt = 0; m_ecnt = 0; m_sticky = 0;
        end else begin
            if (err && m_ecnt < 65535) m_ecnt++;
            if (finc && m_fcnt < 65535) m_fcnt++;
            if (err) m_sticky = 1;
        end
        if (wr) begin
            case (addr)
                0: begin m_en = (din & 1) != 0; m_mon = ((din >> 7) & 1) != 0; m_chid = (din >> 8) & 127; end
                1: m_wpr = din & 12'hFFF;
                2: m_rpf = din & 15;
                default: ;
            endcase
        end
        m_lock = (m_state == 2);
        m_err  = err;
        if (rd) m_dout = rdv;
    endtask

    task automatic set_idle();
        bus.cfg_n_cs = 1'b1; bus.cfg_n_we = 1'b1; bus.cfg_n_oe = 1'b1;
        bus.cfg_addr = 4'h0; bus.cfg_din = 16'h0000;
        bus.data_in  = '0;   bus.chid_in = '0;
    endtask

    // One clock: step the model, then compare all outputs after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("lock", 32'(bus.lock), 32'(m_lock));
        check("err_pulse", 32'(bus.err_pulse), 32'(m_err));
        check("cfg_dout", 32'(bus.cfg_dout), 32'(m_dout));
    endtask

    function automatic logic [DATA_W-1:0] rand_payload();
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = 1'($urandom);
        return p;
    endfunction

    task automatic drive_word(input bit valid, input bit fs, input bit rs, input int chid);
        bus.data_in = {valid, fs, rs, rand_payload()};
        bus.chid_in = CHID_W'(chid);
    endtask

    task automatic send_word(input bit valid, input bit fs, input bit rs, input int chid);
        drive_word(valid, fs, rs, chid);
        cycle();
        bus.data_in = '0;
    endtask

    task automatic send_stream(input int chid, input int w, input int r, input int start, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (start + k) % (w * r);
            send_word(1'b1, idx == 0, idx % w == 0, chid);
        end
    endtask

    task automatic cfg_write(input int addr, input int din);
        bus.cfg_n_cs = 1'b0; bus.cfg_n_we = 1'b0;
        bus.cfg_addr = 4'(addr); bus.cfg_din = 16'(din);
        cycle();
        bus.cfg_n_cs = 1'b1; bus.cfg_n_we = 1'b1;
    endtask

    task automatic cfg_read(input int addr, output logic [15:0] data);
        bus.cfg_n_cs = 1'b0; bus.cfg_n_oe = 1'b0;
        bus.cfg_addr = 4'(addr);
        cycle();
        bus.cfg_n_cs = 1'b1; bus.cfg_n_oe = 1'b1;
        data = bus.cfg_dout;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     vecs[9];
        logic [15:0] d;
        int          w, r, we_, re_, sel, mon, ctrl, gidx, pick, chid;
        bit          fs, rs;

        vecs[0] = '{4'h1, 16'h0050, "rst_wpr"};
        vecs[1] = '{4'h2, 16'h0004, "rst_rpf"};
        vecs[2] = '{4'h0, 16'h0000, "rst_ctrl"};
        vecs[3] = '{4'h3, 16'h0000, "rst_status"};
        vecs[4] = '{4'h4, 16'h0000, "rst_frame_cnt"};
        vecs[5] = '{4'h5, 16'h0000, "rst_err_cnt"};
        vecs[6] = '{4'h6, 16'h0000, "rst_word_pos"};
        vecs[7] = '{4'h7, 16'h0000, "unmapped_7"};
        vecs[8] = '{4'hF, 16'h0000, "unmapped_f"};

        set_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_lock", 32'(bus.lock), 32'h0);
        check("reset_err_pulse", 32'(bus.err_pulse), 32'h0);
        check("reset_cfg_dout", 32'(bus.cfg_dout), 32'h0);
        rst = 1'b0;

        // Register map after reset.
        foreach (vecs[i]) begin
            cfg_read(int'(vecs[i].addr), d);
            check(vecs[i].name, 32'(d), 32'(vecs[i].exp));
        end

        // Acquire and lock on clean frames of channel 3.
        cfg_write(1, 4);
        cfg_write(2, 2);
        cfg_write(0, 16'h0301);
        send_stream(3, 4, 2, 0, 8);
        check("lock_after_1st_fs", 32'(bus.lock), 32'h0);
        send_word(1'b1, 1'b1, 1'b1, 3);
        check("lock_after_2nd_fs", 32'(bus.lock), 32'h1);
        send_stream(3, 4, 2, 1, 7 + 8);
        cfg_read(4, d); check("frame_cnt_locked", 32'(d), 32'h2);
        cfg_read(5, d); check("err_cnt_locked", 32'(d), 32'h0);
        cfg_read(3, d); check("status_locked", 32'(d), 32'h2);

        // Missing row start on word 4 breaks lock.
        send_stream(3, 4, 2, 0, 4);
        send_word(1'b1, 1'b0, 1'b0, 3);
        check("err_pulse_high", 32'(bus.err_pulse), 32'h1);
        check("lock_lost", 32'(bus.lock), 32'h0);
        cycle();
        check("err_pulse_one_cycle", 32'(bus.err_pulse), 32'h0);
        cfg_read(5, d); check("err_cnt_after_err", 32'(d), 32'h1);
        cfg_read(3, d); check("status_after_err", 32'(d), 32'h4);

        // Other-channel words with bad flags are ignored while locked.
        send_stream(3, 4, 2, 0, 9);
        check("relock", 32'(bus.lock), 32'h1);
        for (int k = 1; k < 8; k++) begin
            send_word(1'b1, 1'b1, 1'b0, 5);
            send_stream(3, 4, 2, k, 1);
        end
        check("lock_with_chid5", 32'(bus.lock), 32'h1);
        cfg_read(5, d); check("err_cnt_chid5", 32'(d), 32'h1);

        // Clear counters, then a geometry write drops lock without an error.
        cfg_write(0, 16'h0303);
        cfg_read(4, d); check("frame_cnt_cleared", 32'(d), 32'h0);
        cfg_read(5, d); check("err_cnt_cleared", 32'(d), 32'h0);
        cfg_read(3, d); check("status_cleared", 32'(d), 32'h2);
        cfg_write(1, 8);
        check("lock_after_wpr", 32'(bus.lock), 32'h0);
        check("no_err_after_wpr", 32'(bus.err_pulse), 32'h0);
        cfg_read(5, d); check("err_cnt_after_wpr", 32'(d), 32'h0);

        // Asynchronous reset mid-frame while locked.
        send_stream(3, 8, 2, 0, 16 + 1 + 5);
        check("lock_before_rst", 32'(bus.lock), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("lock_async_rst", 32'(bus.lock), 32'h0);
        check("err_pulse_async_rst", 32'(bus.err_pulse), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_read(6, d); check("word_pos_after_rst", 32'(d), 32'h0);
        cfg_read(1, d); check("wpr_after_rst", 32'(d), 32'h50);

        // Randomized traffic with small geometries against the model.
        for (int seg = 0; seg < 8; seg++) begin
            w    = $urandom_range(0, 5);
            r    = $urandom_range(0, 3);
            sel  = $urandom_range(0, 3);
            mon  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ctrl = (sel << 8) | (mon << 7) | 1;
            we_  = (w == 0) ? 1 : w;
            re_  = (r == 0) ? 1 : r;
            cfg_write(1, w);
            cfg_write(2, r);
            cfg_write(0, ctrl);
            gidx = 0;
            for (int c = 0; c < 300; c++) begin
                pick = $urandom_range(0, 99);
                if (pick < 8) begin
                    bus.cfg_n_cs = 1'b0; bus.cfg_n_oe = 1'b0;
                    bus.cfg_addr = 4'($urandom);
                end else if (pick < 10) begin
                    bus.cfg_n_cs = 1'b0; bus.cfg_n_we = 1'b0;
                    bus.cfg_addr = 4'h0; bus.cfg_din = 16'(ctrl | 2);
                end else if (pick == 10) begin
                    bus.cfg_n_cs = 1'b0; bus.cfg_n_we = 1'b0;
                    bus.cfg_addr = 4'h1; bus.cfg_din = 16'(w);
                end else if (pick == 11) begin
                    bus.cfg_n_cs = 1'b0; bus.cfg_n_we = 1'b0;
                    bus.cfg_addr = 4'($urandom_range(3, 15)); bus.cfg_din = 16'($urandom);
                end
                if ($urandom_range(0, 3) != 0) begin
                    chid = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : sel;
                    if (chid == sel) begin
                        fs = (gidx == 0);
                        rs = (gidx % we_ == 0);
                        if ($urandom_range(0, 24) == 0) fs = ~fs;
                        if ($urandom_range(0, 24) == 0) rs = ~rs;
                        gidx = (gidx + 1) % (we_ * re_);
                    end else begin
                        fs = 1'($urandom);
                        rs = 1'($urandom);
                    end
                    drive_word(1'b1, fs, rs, chid);
                end else begin
                    drive_word(1'b0, 1'($urandom), 1'($urandom), sel);
                end
                cycle();
                set_idle();
            end
            cfg_read(4, d); check("rand_frame_cnt", 32'(d), 32'(m_fcnt));
            cfg_read(5, d); check("rand_err_cnt", 32'(d), 32'(m_ecnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/odu_frame_checker.md
ODU_FRAME_CHECKER -- requirements
Module: odu_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 384, ODU payload width per word.
REQ-002 SHALL have parameter CHID_W, default 7, channel ID width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  in  DATA_W+3  generator output word: [DATA_W+2]=valid, [DATA_W+1]=fs_start, [DATA_W]=rs_start, [DATA_W-1:0]=payload.
REQ-006 SHALL have port chid_in  in  CHID_W  channel ID qualifying data_in.
REQ-007 SHALL have ports cfg_n_cs, cfg_n_we, cfg_n_oe  in  1 each  active-low config strobes.
REQ-008 SHALL have ports cfg_addr  in  4, cfg_din  in  16, cfg_dout  out  16  config address, write data, read data.
REQ-009 SHALL have port lock  out  1  high while state is SYNC.
REQ-010 SHALL have port err_pulse  out  1  one-cycle pulse per detected framing error.

Function
REQ-011 Write SHALL occur on each rising clk with cfg_n_cs=0 and cfg_n_we=0; cfg_n_oe ignored for writes.
REQ-012 Read: cfg_dout SHALL be registered, loaded with selected register one cycle after a rising clk with cfg_n_cs=0, cfg_n_oe=0; otherwise it holds.
REQ-013 Register map: 0x0 CTRL RW (bit0 enable, bit1 clear self-clearing reads 0, bit7 monitor_all, bits[14:8] chid_sel); 0x1 WPR RW [11:0] words per row; 0x2 RPF RW [3:0] rows per frame; 0x3 STATUS RO ([1:0] state, bit2 sticky error); 0x4 FRAME_CNT RO; 0x5 ERR_CNT RO; 0x6 WORD_POS RO ([11:0] wpos, [15:12] rpos); unmapped reads return 0x0000, unmapped writes ignored.
REQ-014 Accepted word SHALL be valid=1 and enable=1 and (monitor_all=1 or chid_in==chid_sel); non-accepted words SHALL change no state.
REQ-015 wpos SHALL count accepted words 0..WPR-1, wrapping to 0 and incrementing rpos; rpos SHALL wrap 0..RPF-1; WPR=0 or RPF=0 SHALL be treated as 1.
REQ-016 Expected flags: exp_rs = (wpos==0); exp_fs = (wpos==0 and rpos==0).
REQ-017 FSM states SHALL be HUNT=0, PRESYNC=1, SYNC=2.
REQ-018 HUNT: accepted word with fs=1 and rs=1 SHALL set wpos=1 (or 0 if WPR=1, rpos advancing), rpos=0, go PRESYNC; fs=1 with rs=0 SHALL count an error and stay HUNT; other words ignored.
REQ-019 PRESYNC/SYNC: accepted word with rs!=exp_rs or fs!=exp_fs SHALL raise err_pulse next cycle, increment ERR_CNT, set sticky error, go HUNT; if that word carries fs=1 and rs=1 it SHALL instead re-acquire directly into PRESYNC per REQ-018.
REQ-020 PRESYNC: correct fs at exp_fs SHALL go SYNC and increment FRAME_CNT; SYNC: each correct fs SHALL increment FRAME_CNT.
REQ-021 FRAME_CNT and ERR_CNT SHALL saturate at 0xFFFF.
REQ-022 CTRL clear SHALL zero both counters and sticky error; clear wins over a same-cycle increment.
REQ-023 Any write to 0x1 or 0x2, or enable=0, SHALL force HUNT with wpos=rpos=0 next cycle, no error counted.
REQ-024 lock SHALL be registered, equal to (state==SYNC), no extra latency beyond state register.
REQ-025 Payload bits SHALL not affect checking.

Reset
REQ-026 On rst: state HUNT, wpos=rpos=0, lock=0, err_pulse=0, cfg_dout=0x0000, CTRL=0x0000, WPR=80, RPF=4, counters and sticky 0; effect immediate, including mid-frame.

Verification
REQ-027 Reset, read 0x1 and 0x2 -> cfg_dout 0x0050 then 0x0004, one cycle after each strobe.
REQ-028 WPR=4, RPF=2, CTRL=0x0301; send 3 clean frames chid 3 -> lock rises after 2nd fs, FRAME_CNT=2, ERR_CNT=0, STATUS=0x0002.
REQ-029 Locked, drop rs on word 4 of frame -> err_pulse one cycle, ERR_CNT=1, lock=0, STATUS=0x0004.
REQ-030 Locked, interleave chid 5 words with bad flags -> ignored, lock stays 1, ERR_CNT unchanged.
REQ-031 Locked, write CTRL=0x0303 -> FRAME_CNT=0, ERR_CNT=0, sticky 0; write WPR=8 -> lock 0, no error.
REQ-032 Assert rst mid-frame while locked -> lock=0 immediately, WORD_POS reads 0x0000 after release.
